add_share_sched: RTL and testbench
==================================

Name: add_share_sched

Overview:
- Scheduler that shares one 9-bit carry-in adder core between NREQ requesters. The core takes X and Y of 9 bits plus Cin, and returns a 10-bit S whose MSB is carry-out.
- Each requester issues a multi-limb addition as a stream of 9-bit limbs. The block arbitrates round-robin and locks the grant for the whole transaction.
- It chains carry between limbs through a register and returns registered per-limb results over a valid/ready interface.
- It sits between the operand producers and the shared adder instance, which is external and driven through the adder_* ports.

Parameters:
- W, 9, limb width; must match the adder core operand width.
- NREQ, 2, number of requesters (2..4).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester limb valid
- req_ready  out  NREQ  per-requester limb accepted this cycle
- req_x  in  NREQ*W  packed operand X limbs; requester i at [i*W +: W]
- req_y  in  NREQ*W  packed operand Y limbs
- req_last  in  NREQ  marks the final limb of a transaction
- adder_x  out  W  to adder core X
- adder_y  out  W  to adder core Y
- adder_cin  out  1  to adder core Cin
- adder_s  in  W+1  from adder core S; bit W is carry-out
- res_valid  out  1  result limb valid
- res_ready  in  1  result consumer ready
- res_sum  out  W  result limb
- res_cout  out  1  carry-out of this limb
- res_id  out  2  index of the requester that owns the result
- res_last  out  1  final limb of a transaction
- busy  out  1  grant locked (transaction in progress)

Behaviour:
- Reset, asynchronous and active-low:
  - res_valid=0, res_sum=0, res_cout=0, res_id=0, res_last=0, busy=0.
  - Internal state: state=IDLE, rr_ptr=0, carry_q=0, first_q=1.
  - Reset asserted mid-transaction aborts it; partial state is discarded.
- States: IDLE and LOCKED.
- IDLE:
  - Combinational round-robin pick: the first asserted req_valid starting at rr_ptr, wrapping.
  - The picked requester is granted in the same cycle, and its first limb may be accepted in that cycle.
- Accept condition: granted requester has valid=1 AND (res_valid=0 OR res_ready=1).
  - req_ready[g] equals the accept condition.
  - Every other req_ready bit is 0.
- Adder drive on accept:
  - adder_x and adder_y take the granted requester's limbs.
  - adder_cin = 0 on the first limb; otherwise adder_cin = carry_q.
  - With no accept, adder_x, adder_y and adder_cin are 0.
- Result register, updated on accept, latency 1 cycle:
  - res_sum <= adder_s[W-1:0]; res_cout <= adder_s[W].
  - res_id <= g; res_last <= req_last[g]; res_valid <= 1.
  - carry_q <= adder_s[W]; first_q <= req_last[g].
- Result consumed with no new accept: res_valid <= 0, other fields hold.
- Throughput: consume and accept in the same cycle gives 1 limb per cycle.
- Backpressure: res_valid=1 and res_ready=0 means req_ready=0 and all result fields hold stable.
- Transitions:
  - IDLE to LOCKED on accepting a non-last limb.
  - LOCKED to IDLE on accepting a limb with req_last=1; rr_ptr <= (g+1) mod NREQ.
  - Single-limb transaction (first and last on the same beat): stays IDLE and rr_ptr advances.
- LOCKED:
  - The grant is held. Other requesters are ignored even when valid.
  - If the owner drops valid, no limb is accepted and carry_q is preserved.
  - busy=1.
- Carry-out of the final limb is reported only through res_cout; no extra result beat is issued.
- req_x, req_y and req_last of requesters without a grant are don't-care.

Optional Feature:
- Macro ADD_SHARE_SUB_EN.
- When defined, add input port req_sub (NREQ bits). It is sampled per limb and must be constant within a transaction.
- If req_sub[g]=1:
  - adder_y = ~req_y limb.
  - adder_cin = 1 on the first limb and carry_q afterwards (two's-complement subtract X-Y).
  - res_cout=1 means no borrow.
- When not defined, the port is absent and the block only adds.

Test Plan:
- Single limb: req0 x=0x1FF, y=0x001, last=1 -> next cycle res_sum=0x000, res_cout=1, res_last=1, res_id=0; busy stays 0.
- Two limbs on req1:
  - Limb 0: x=0x1FF, y=0x001 -> res_sum=0x000, res_cout=1, busy=1.
  - Limb 1: x=0x000, y=0x000, last=1 -> adder_cin=1; res_sum=0x001, res_cout=0; busy returns to 0.
- Round-robin: from reset both requesters valid with single-limb transactions -> req0 is served first, then req1, then req0; no cycle has two req_ready bits set.
- Backpressure: hold res_ready=0 for 3 cycles while res_valid=1 -> all req_ready=0 and res_* stable; raise res_ready -> the next limb is accepted in that same cycle.
- Lock and stall:
  - req0 sends a non-last limb, then drops valid for 2 cycles while req1 is valid -> req1 is never granted; carry_q is kept for req0's next limb.
  - Assert rst_n=0 mid-transaction -> all outputs 0, state IDLE, rr_ptr 0.
- ADD_SHARE_SUB_EN: req0 sub=1, x=0x005, y=0x003, last=1 -> adder_y=0x1FC, adder_cin=1; res_sum=0x002, res_cout=1.

Source files
------------

// File: rtl/add_share_sched.sv
// Shares one external W-bit carry-in adder among NREQ multi-limb requesters, round-robin, grant locked per transaction.
// Latency: 1 cycle from limb accept to registered result; 1 limb/cycle when the result is consumed as it is produced.
// Backpressure: res_valid && !res_ready stalls all req_ready and holds results. Optional subtract: `define ADD_SHARE_SUB_EN.
`timescale 1ns/1ps
module add_share_sched #(
    parameter int W    = 9,
    parameter int NREQ = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_x,
    input  logic [NREQ*W-1:0] req_y,
    input  logic [NREQ-1:0]   req_last,
`ifdef ADD_SHARE_SUB_EN
    input  logic [NREQ-1:0]   req_sub,
`endif
    output logic [W-1:0]      adder_x,
    output logic [W-1:0]      adder_y,
    output logic              adder_cin,
    input  logic [W:0]        adder_s,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [W-1:0]      res_sum,
    output logic              res_cout,
    output logic [1:0]        res_id,
    output logic              res_last,
    output logic              busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t       state;
    logic [1:0]   rr_ptr;
    logic [1:0]   owner;
    logic         carry_q;
    logic         first_q;

    logic [1:0]   pick;
    logic [2:0]   t;
    logic [1:0]   g;
    logic         g_vld;
    logic [W-1:0] g_x;
    logic [W-1:0] g_y;
    logic         g_last;
    logic         g_sub;
    logic         accept;
    logic [1:0]   rr_next;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        t    = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            t = {1'b0, rr_ptr} + 3'(j);
            if (t >= 3'(NREQ))
                t = t - 3'(NREQ);
            for (int i = 0; i < NREQ; i++)
                if (3'(i) == t && req_valid[i])
                    pick = t[1:0];
        end
    end

    assign g = (state == LOCKED) ? owner : pick;

    always_comb begin
        g_vld  = 1'b0;
        g_x    = '0;
        g_y    = '0;
        g_last = 1'b0;
        g_sub  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (2'(i) == g) begin
                g_vld  = req_valid[i];
                g_x    = req_x[i*W +: W];
                g_y    = req_y[i*W +: W];
                g_last = req_last[i];
`ifdef ADD_SHARE_SUB_EN
                g_sub  = req_sub[i];
`endif
            end
        end
    end

    // Gated by rst_n so nothing leaks to the adder or requesters while held in reset.
    assign accept = rst_n && g_vld && (!res_valid || res_ready);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++)
            req_ready[i] = accept && (2'(i) == g);
    end

    assign adder_x   = accept ? g_x : '0;
    assign adder_y   = !accept ? '0 : (g_sub ? ~g_y : g_y);
    assign adder_cin = accept && (first_q ? g_sub : carry_q);

    assign rr_next = (g == 2'(NREQ - 1)) ? 2'd0 : g + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            carry_q   <= 1'b0;
            first_q   <= 1'b1;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= '0;
            res_last  <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_sum   <= adder_s[W-1:0];
            res_cout  <= adder_s[W];
            res_id    <= g;
            res_last  <= g_last;
            carry_q   <= adder_s[W];
            first_q   <= g_last;
            if (g_last) begin
                state  <= IDLE;
                busy   <= 1'b0;
                rr_ptr <= rr_next;
            end else begin
                state  <= LOCKED;
                busy   <= 1'b1;
                owner  <= g;
            end
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_add_share_sched.sv
// Randomised bench for add_share_sched with a limb-level arithmetic model and directed literal checks.
`timescale 1ns/1ps
module tb_add_share_sched;
    localparam int W    = 9;
    localparam int NREQ = 2;
`ifdef ADD_SHARE_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_x;
    logic [NREQ*W-1:0] req_y;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_sub;
    logic [W-1:0]      adder_x;
    logic [W-1:0]      adder_y;
    logic              adder_cin;
    logic [W:0]        adder_s;
    logic              res_valid;
    logic              res_ready;
    logic [W-1:0]      res_sum;
    logic              res_cout;
    logic [1:0]        res_id;
    logic              res_last;
    logic              busy;

    // The external adder core.
    assign adder_s = {1'b0, adder_x} + {1'b0, adder_y} + {{W{1'b0}}, adder_cin};

    always #5 clk = ~clk;

    add_share_sched #(.W(W), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_last(req_last),
`ifdef ADD_SHARE_SUB_EN
        .req_sub(req_sub),
`endif
        .adder_x(adder_x), .adder_y(adder_y), .adder_cin(adder_cin), .adder_s(adder_s),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .res_last(res_last),
        .busy(busy)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    // Model: who owns the adder, who is next in rotation, running carry of the open transaction,
    // and the result beat the DUT should currently present.
    int m_rv, m_sum, m_cout, m_id, m_last;
    int m_busy, m_owner, m_rr, m_carry, m_first;
    logic [NREQ-1:0] acc;

    task automatic model_reset();
        m_rv = 0; m_sum = 0; m_cout = 0; m_id = 0; m_last = 0;
        m_busy = 0; m_owner = 0; m_rr = 0; m_carry = 0; m_first = 1;
    endtask

    task automatic model_step();
        int g, xv, yv, ex, ey, ecin, s, sub;
        bit gv, a, lst;
        acc = '0;
        if (!rst_n) begin
            model_reset();
            chk("rst_res_valid", res_valid, 0);
            chk("rst_res_sum", res_sum, 0);
            chk("rst_res_cout", res_cout, 0);
            chk("rst_res_id", res_id, 0);
            chk("rst_res_last", res_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            return;
        end
        chk("res_valid", res_valid, m_rv);
        chk("res_sum", res_sum, m_sum);
        chk("res_cout", res_cout, m_cout);
        chk("res_id", res_id, m_id);
        chk("res_last", res_last, m_last);
        chk("busy", busy, m_busy);

        gv = 0; g = 0;
        if (m_busy != 0) begin
            g = m_owner; gv = req_valid[g];
        end else begin
            for (int k = NREQ - 1; k >= 0; k--)
                if (req_valid[(m_rr + k) % NREQ]) begin
                    g = (m_rr + k) % NREQ; gv = 1;
                end
        end
        a = gv && (m_rv == 0 || res_ready);
        chk("req_ready", req_ready, a ? (1 << g) : 0);

        if (a) begin
            xv   = int'(req_x[g*W +: W]);
            yv   = int'(req_y[g*W +: W]);
            lst  = req_last[g];
            sub  = SUB_EN ? int'(req_sub[g]) : 0;
            ex   = xv;
            ey   = (sub != 0) ? (yv ^ 'h1FF) : yv;
            ecin = (m_first != 0) ? sub : m_carry;
            chk("adder_x", adder_x, ex);
            chk("adder_y", adder_y, ey);
            chk("adder_cin", adder_cin, ecin);
            s = ex + ey + ecin;
            m_rv = 1; m_sum = s & 'h1FF; m_cout = s >> W; m_id = g; m_last = lst;
            m_carry = m_cout; m_first = lst;
            if (lst) begin
                m_busy = 0; m_rr = (g + 1) % NREQ;
            end else begin
                m_busy = 1; m_owner = g;
            end
            acc[g] = 1'b1;
        end else begin
            chk("adder_idle", {adder_x, adder_y, adder_cin}, 0);
            if (res_ready) m_rv = 0;
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int i, input logic [W-1:0] x, input logic [W-1:0] y, input logic l);
        req_x[i*W +: W] = x;
        req_y[i*W +: W] = y;
        req_last[i]     = l;
    endtask

    int rem [NREQ];

    task automatic new_limb(input int i);
        logic [W-1:0] x, y;
        x = ($urandom_range(0, 3) == 0) ? 9'h1FF : W'($urandom_range(0, 511));
        y = ($urandom_range(0, 3) == 0) ? 9'h001 : W'($urandom_range(0, 511));
        drive(i, x, y, rem[i] == 1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; req_last = '0;
        req_sub = '0; res_ready = 1'b1;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("reset_res_valid", res_valid, 0);
        chk("reset_busy", busy, 0);

        // Single-limb transaction wraps to zero with carry-out.
        drive(0, 9'h1FF, 9'h001, 1'b1); req_valid = 2'b01;
        cyc();
        chk("t1_sum", res_sum, 9'h000);
        chk("t1_cout", res_cout, 1);
        chk("t1_last", res_last, 1);
        chk("t1_id", res_id, 0);
        chk("t1_busy", busy, 0);
        req_valid = '0; cyc();

        // Two limbs on req1: carry chains into the second limb.
        drive(1, 9'h1FF, 9'h001, 1'b0); req_valid = 2'b10;
        cyc();
        chk("t2a_sum", res_sum, 9'h000);
        chk("t2a_cout", res_cout, 1);
        chk("t2a_busy", busy, 1);
        drive(1, 9'h000, 9'h000, 1'b1);
        #1;
        chk("t2_adder_cin", adder_cin, 1);
        cyc();
        chk("t2b_sum", res_sum, 9'h001);
        chk("t2b_cout", res_cout, 0);
        chk("t2b_busy", busy, 0);
        req_valid = '0; cyc();

        // Round robin with both requesters always valid.
        drive(0, 9'h010, 9'h020, 1'b1); drive(1, 9'h030, 9'h040, 1'b1); req_valid = 2'b11;
        cyc(); chk("rr_first", res_id, 0);
        cyc(); chk("rr_second", res_id, 1);
        cyc(); chk("rr_third", res_id, 0);
        req_valid = '0; cyc();

        // Backpressure holds results and stalls acceptance.
        drive(0, 9'h0AA, 9'h011, 1'b1); req_valid = 2'b01;
        cyc(); chk("bp_sum", res_sum, 9'h0BB);
        res_ready = 1'b0; drive(0, 9'h100, 9'h011, 1'b1);
        repeat (3) begin
            #1;
            chk("bp_ready", req_ready, 0);
            chk("bp_hold", res_sum, 9'h0BB);
            cyc();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_release_ready", req_ready, 2'b01);
        cyc(); chk("bp_next_sum", res_sum, 9'h111);
        req_valid = '0; cyc();

        // Locked owner stalls; the other requester is ignored and carry survives.
        drive(0, 9'h1FF, 9'h001, 1'b0); req_valid = 2'b01;
        cyc(); chk("lock_busy", busy, 1);
        drive(1, 9'h055, 9'h055, 1'b1); req_valid = 2'b10;
        repeat (2) begin
            #1;
            chk("lock_ready", req_ready, 0);
            cyc();
        end
        drive(0, 9'h000, 9'h000, 1'b1); req_valid = 2'b01;
        cyc();
        chk("lock_carry_sum", res_sum, 9'h001);
        chk("lock_id", res_id, 0);
        chk("lock_done_busy", busy, 0);
        req_valid = '0; cyc();

        // Reset in the middle of a transaction; rotation restarts at req0.
        drive(0, 9'h123, 9'h045, 1'b0); req_valid = 2'b01;
        cyc(); chk("mid_busy", busy, 1);
        rst_n = 1'b0; drive(0, 9'h001, 9'h002, 1'b1); drive(1, 9'h003, 9'h004, 1'b1);
        req_valid = 2'b11;
        #1;
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_sum", res_sum, 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("mid_rst_rr", res_id, 0);
        chk("mid_rst_rr_sum", res_sum, 9'h003);
        req_valid = '0; cyc();

`ifdef ADD_SHARE_SUB_EN
        req_sub = 2'b01; drive(0, 9'h005, 9'h003, 1'b1); req_valid = 2'b01;
        #1;
        chk("sub_adder_y", adder_y, 9'h1FC);
        chk("sub_adder_cin", adder_cin, 1);
        cyc();
        chk("sub_sum", res_sum, 9'h002);
        chk("sub_cout", res_cout, 1);
        req_valid = '0; req_sub = '0; cyc();
`endif

        // Random traffic.
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = $urandom_range(1, 4);
            req_sub[i] = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            new_limb(i);
        end
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++)
                req_valid[i] = ($urandom_range(0, 9) < 7);
            res_ready = ((c / 200) % 3 == 2) ? ($urandom_range(0, 3) == 0)
                                             : ($urandom_range(0, 3) != 0);
            cyc();
            for (int i = 0; i < NREQ; i++)
                if (acc[i]) begin
                    rem[i]--;
                    if (rem[i] == 0) begin
                        rem[i] = $urandom_range(1, 4);
                        req_sub[i] = SUB_EN ? 1'($urandom_range(0, 1)) : 1'b0;
                    end
                    new_limb(i);
                end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
